// File: rtl/load_store_unit_if.sv
// Core-side request/response and memory-bus signals of the load/store unit.
// slave = the LSU itself; master = the core plus memory environment around it.
interface load_store_unit_if;
    logic        lsu_valid;
    logic        lsu_we;
    logic [2:0]  lsu_funct3;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [31:0] lsu_rdata;
    logic        lsu_done;
    logic        lsu_stall;
    logic        lsu_misalign;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport slave (
        input  lsu_valid, lsu_we, lsu_funct3, lsu_addr, lsu_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output lsu_rdata, lsu_done, lsu_stall, lsu_misalign,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output lsu_valid, lsu_we, lsu_funct3, lsu_addr, lsu_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  lsu_rdata, lsu_done, lsu_stall, lsu_misalign,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one word-aligned bus transaction per request, B/H/W lane steering and extension.
// Latency: load done 3 cycles, store 2 cycles after the request is taken (plus grant wait cycles).
// Backpressure: mem_req and mem_* held stable until mem_gnt; lsu_stall high while a request is pending.
// Optional LSU_MISALIGN_TRAP_EN: misaligned H/W accesses complete with lsu_misalign and no bus request.
module load_store_unit (
    input  logic             clk,
    input  logic             rst_n,
    load_store_unit_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t      state_q;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;
    logic [31:0] rdata_q;
    logic        done_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [3:0]  mem_be_q;

    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] rdata_d;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        trap_d;

`ifdef LSU_MISALIGN_TRAP_EN
    logic        misalign_q;
`endif

    // funct3[1:0] selects the access size; 11 falls through to word
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = bus.lsu_wdata;
        case (bus.lsu_funct3[1:0])
            2'b00: begin
                be_d    = 4'b0001 << bus.lsu_addr[1:0];
                wdata_d = {4{bus.lsu_wdata[7:0]}};
            end
            2'b01: begin
                be_d    = bus.lsu_addr[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{bus.lsu_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (addr_lo_q)
            2'd0:    ld_byte = bus.mem_rdata[7:0];
            2'd1:    ld_byte = bus.mem_rdata[15:8];
            2'd2:    ld_byte = bus.mem_rdata[23:16];
            default: ld_byte = bus.mem_rdata[31:24];
        endcase
        ld_half = addr_lo_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        rdata_d = bus.mem_rdata;
        case (funct3_q)
            3'b000:  rdata_d = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  rdata_d = {{16{ld_half[15]}}, ld_half};
            3'b100:  rdata_d = {24'd0, ld_byte};
            3'b101:  rdata_d = {16'd0, ld_half};
            default: ;
        endcase
    end

    always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
        trap_d = ((bus.lsu_funct3[1:0] == 2'b01) && bus.lsu_addr[0]) ||
                 (bus.lsu_funct3[1] && (bus.lsu_addr[1:0] != 2'b00));
`else
        trap_d = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            funct3_q    <= 3'd0;
            addr_lo_q   <= 2'd0;
            rdata_q     <= 32'd0;
            done_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_be_q    <= 4'd0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.lsu_valid) begin
                        we_q      <= bus.lsu_we;
                        funct3_q  <= bus.lsu_funct3;
                        addr_lo_q <= bus.lsu_addr[1:0];
                        if (trap_d) begin
                            state_q    <= S_DONE;
                            done_q     <= 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
                            misalign_q <= 1'b1;
`endif
                        end else begin
                            state_q     <= S_REQ;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= bus.lsu_we;
                            mem_addr_q  <= {bus.lsu_addr[31:2], 2'b00};
                            mem_wdata_q <= wdata_d;
                            mem_be_q    <= be_d;
                        end
                    end
                end
                S_REQ: begin
                    if (bus.mem_gnt) begin
                        mem_req_q <= 1'b0;
                        if (we_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (bus.mem_rvalid) begin
                        rdata_q <= rdata_d;
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q    <= S_IDLE;
`ifdef LSU_MISALIGN_TRAP_EN
                    misalign_q <= 1'b0;
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.lsu_rdata = rdata_q;
    assign bus.lsu_done  = done_q;
    assign bus.lsu_stall = bus.lsu_valid & ~done_q;
`ifdef LSU_MISALIGN_TRAP_EN
    assign bus.lsu_misalign = misalign_q;
`else
    assign bus.lsu_misalign = 1'b0;
`endif
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus a randomized scoreboard run.
module tb_load_store_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_if bus();
    load_store_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_cmp = 0;
    int n_fail = 0;
    logic [31:0] last_rdata = 32'd0;

    typedef struct {
        logic [31:0] rdata;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
        logic        misal;
        int          lat;
        int          reqs;
    } exp_t;
    exp_t sb_q[$];

    int          o_lat, o_reqs, o_extra;
    logic [31:0] o_rdata, o_addr, o_wdata;
    logic [3:0]  o_be;
    logic        o_we, o_misal;
    bit          o_stall_ok, o_stable;

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
        logic [31:0] sb, sh;
        sb = w >> {a, 3'b000};
        sh = w >> {a[1], 4'b0000};
        case (f3)
            3'b000:  return {{24{sb[7]}}, sb[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b100:  return {24'd0, sb[7:0]};
            3'b101:  return {16'd0, sh[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [1:0] a);
        if (f3[1:0] == 2'b00) return 4'(1 << a);
        if (f3[1:0] == 2'b01) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (f3[1:0] == 2'b00) return {d[7:0], d[7:0], d[7:0], d[7:0]};
        if (f3[1:0] == 2'b01) return {d[15:0], d[15:0]};
        return d;
    endfunction

    function automatic logic exp_misal(input logic [2:0] f3, input logic [1:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        return ((f3[1:0] == 2'b01) && a[0]) || (f3[1] && (a != 2'b00));
`else
        return 1'b0;
`endif
    endfunction

    // Plays core and memory: drives one request, grants after gnt_wait refused cycles,
    // returns read data the cycle after the grant, and records what the DUT did.
    task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] word, input int gnt_wait);
        int cyc = 0;
        int reqs = 0;
        bit granted = 0;
        bit rv_sent = 0;
        o_lat = -1; o_stall_ok = 1; o_stable = 1; o_extra = 0;
        o_addr = 'x; o_wdata = 'x; o_be = 'x; o_we = 'x; o_rdata = 'x; o_misal = 'x;
        bus.lsu_valid  = 1'b1;
        bus.lsu_we     = we;
        bus.lsu_funct3 = f3;
        bus.lsu_addr   = addr;
        bus.lsu_wdata  = wdata;
        bus.mem_rdata  = ~word;
        while (cyc < 60) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = ~word;
            if (bus.lsu_done === 1'b1) begin
                o_lat   = cyc;
                o_rdata = bus.lsu_rdata;
                o_misal = bus.lsu_misalign;
                if (bus.lsu_stall !== 1'b0) o_stall_ok = 0;
                break;
            end
            if (bus.lsu_stall !== 1'b1) o_stall_ok = 0;
            if (bus.mem_req === 1'b1) begin
                reqs++;
                if (reqs == 1) begin
                    o_addr = bus.mem_addr; o_wdata = bus.mem_wdata; o_be = bus.mem_be; o_we = bus.mem_we;
                end else if (bus.mem_addr !== o_addr || bus.mem_wdata !== o_wdata ||
                             bus.mem_be !== o_be || bus.mem_we !== o_we) begin
                    o_stable = 0;
                end
                if (reqs > gnt_wait) begin
                    bus.mem_gnt = 1'b1;
                    granted = 1;
                end
            end else if (granted && !we && !rv_sent) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = word;
                rv_sent = 1;
            end
        end
        o_reqs = reqs;
        bus.lsu_valid  = 1'b0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (bus.lsu_done !== 1'b0 || bus.mem_req !== 1'b0) o_extra++;
        end
    endtask

    task automatic test_reset();
        bus.lsu_valid = 0; bus.lsu_we = 0; bus.lsu_funct3 = 0; bus.lsu_addr = 0; bus.lsu_wdata = 0;
        bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
        rst_n = 1'b0;
        #12;
        n_cmp++;
        if ({bus.lsu_rdata, bus.lsu_done, bus.lsu_misalign, bus.mem_req, bus.mem_we,
             bus.mem_addr, bus.mem_wdata, bus.mem_be} !== 104'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdata=%h done=%b mis=%b req=%b we=%b addr=%h wdata=%h be=%b expected all zero",
                     bus.lsu_rdata, bus.lsu_done, bus.lsu_misalign, bus.mem_req, bus.mem_we,
                     bus.mem_addr, bus.mem_wdata, bus.mem_be);
        end
        n_cmp++;
        if (bus.lsu_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", bus.lsu_stall); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load_byte();
        run_op(1'b0, 3'b000, 32'h0000_1003, 32'd0, 32'h80FF_1234, 0);
        n_cmp++; if (o_rdata !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_rdata: got %h expected ffffff80", o_rdata); end
        n_cmp++; if (o_lat !== 3) begin n_fail++; $display("FAIL lb_latency: got %0d expected 3", o_lat); end
        n_cmp++; if (o_addr !== 32'h0000_1000 || o_we !== 1'b0) begin n_fail++; $display("FAIL lb_bus: got addr=%h we=%b expected 00001000 0", o_addr, o_we); end
        n_cmp++; if (o_reqs !== 1 || o_extra !== 0 || !o_stall_ok) begin n_fail++; $display("FAIL lb_handshake: got reqs=%0d extra=%0d stall_ok=%0d expected 1 0 1", o_reqs, o_extra, o_stall_ok); end
        last_rdata = 32'hFFFF_FF80;
    endtask

    task automatic test_load_half();
        run_op(1'b0, 3'b101, 32'h0000_2002, 32'd0, 32'hBEEF_0000, 0);
        n_cmp++; if (o_rdata !== 32'h0000_BEEF) begin n_fail++; $display("FAIL lhu_rdata: got %h expected 0000beef", o_rdata); end
        run_op(1'b0, 3'b001, 32'h0000_2002, 32'd0, 32'hBEEF_0000, 0);
        n_cmp++; if (o_rdata !== 32'hFFFF_BEEF) begin n_fail++; $display("FAIL lh_rdata: got %h expected ffffbeef", o_rdata); end
        n_cmp++; if (o_addr !== 32'h0000_2000 || o_lat !== 3) begin n_fail++; $display("FAIL lh_bus: got addr=%h lat=%0d expected 00002000 3", o_addr, o_lat); end
        last_rdata = 32'hFFFF_BEEF;
    endtask

    task automatic test_store_byte();
        run_op(1'b1, 3'b000, 32'h0000_3001, 32'h0000_00A5, 32'h5555_5555, 0);
        n_cmp++; if (o_be !== 4'b0010) begin n_fail++; $display("FAIL sb_be: got %b expected 0010", o_be); end
        n_cmp++; if (o_wdata !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL sb_wdata: got %h expected a5a5a5a5", o_wdata); end
        n_cmp++; if (o_addr !== 32'h0000_3000 || o_we !== 1'b1) begin n_fail++; $display("FAIL sb_bus: got addr=%h we=%b expected 00003000 1", o_addr, o_we); end
        n_cmp++; if (o_lat !== 2) begin n_fail++; $display("FAIL sb_latency: got %0d expected 2", o_lat); end
        n_cmp++; if (o_rdata !== last_rdata) begin n_fail++; $display("FAIL sb_rdata_hold: got %h expected %h", o_rdata, last_rdata); end
    endtask

    task automatic test_store_stall();
        run_op(1'b1, 3'b010, 32'h0000_5000, 32'h1234_5678, 32'd0, 4);
        n_cmp++; if (o_reqs !== 5) begin n_fail++; $display("FAIL sw_req_cycles: got %0d expected 5", o_reqs); end
        n_cmp++; if (!o_stable) begin n_fail++; $display("FAIL sw_bus_stable: got unstable expected stable"); end
        n_cmp++; if (!o_stall_ok) begin n_fail++; $display("FAIL sw_stall: got stall dropped expected high until done"); end
        n_cmp++; if (o_lat !== 6 || o_extra !== 0) begin n_fail++; $display("FAIL sw_done: got lat=%0d extra=%0d expected 6 0", o_lat, o_extra); end
        n_cmp++; if (o_be !== 4'b1111 || o_wdata !== 32'h1234_5678) begin n_fail++; $display("FAIL sw_data: got be=%b wdata=%h expected 1111 12345678", o_be, o_wdata); end
    endtask

    task automatic test_misalign();
        run_op(1'b0, 3'b010, 32'h0000_4002, 32'd0, 32'hCAFE_F00D, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        n_cmp++; if (o_reqs !== 0 || o_lat !== 1) begin n_fail++; $display("FAIL lw_trap: got reqs=%0d lat=%0d expected 0 1", o_reqs, o_lat); end
        n_cmp++; if (o_misal !== 1'b1 || o_rdata !== last_rdata) begin n_fail++; $display("FAIL lw_trap_flag: got mis=%b rdata=%h expected 1 %h", o_misal, o_rdata, last_rdata); end
        run_op(1'b1, 3'b001, 32'h0000_4001, 32'h0000_7777, 32'd0, 0);
        n_cmp++; if (o_reqs !== 0 || o_misal !== 1'b1 || o_lat !== 1) begin n_fail++; $display("FAIL sh_trap: got reqs=%0d mis=%b lat=%0d expected 0 1 1", o_reqs, o_misal, o_lat); end
`else
        n_cmp++; if (o_addr !== 32'h0000_4000 || o_lat !== 3) begin n_fail++; $display("FAIL lw_unaligned: got addr=%h lat=%0d expected 00004000 3", o_addr, o_lat); end
        n_cmp++; if (o_misal !== 1'b0 || o_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL lw_unaligned_data: got mis=%b rdata=%h expected 0 cafef00d", o_misal, o_rdata); end
        last_rdata = 32'hCAFE_F00D;
`endif
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        bus.lsu_valid = 1'b1; bus.lsu_we = 1'b0; bus.lsu_funct3 = 3'b010; bus.lsu_addr = 32'h0000_6000;
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL rst_mid_req: got %b expected 1", bus.mem_req); end
        bus.mem_gnt = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        rst_n = 1'b0;
        bus.lsu_valid = 1'b0;
        #1;
        n_cmp++; if (bus.lsu_rdata !== 32'd0 || bus.mem_req !== 1'b0 || bus.mem_addr !== 32'd0) begin n_fail++; $display("FAIL rst_mid_clear: got rdata=%h req=%b addr=%h expected 0 0 0", bus.lsu_rdata, bus.mem_req, bus.mem_addr); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1111_1111;
        repeat (3) begin
            @(negedge clk);
            bus.mem_rvalid = 1'b0;
            if (bus.lsu_done !== 1'b0) dones++;
        end
        n_cmp++; if (dones !== 0 || bus.lsu_rdata !== 32'd0) begin n_fail++; $display("FAIL rst_mid_late_rvalid: got dones=%0d rdata=%h expected 0 00000000", dones, bus.lsu_rdata); end
        last_rdata = 32'd0;
        run_op(1'b0, 3'b100, 32'h0000_6001, 32'd0, 32'h0000_9A00, 0);
        n_cmp++; if (o_lat !== 3 || o_rdata !== 32'h0000_009A) begin n_fail++; $display("FAIL rst_mid_recover: got lat=%0d rdata=%h expected 3 0000009a", o_lat, o_rdata); end
        last_rdata = 32'h0000_009A;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            exp_t e;
            logic we;
            logic [2:0] f3;
            logic [31:0] a, d, w;
            int gw;
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom; d = $urandom; w = $urandom;
            gw = $urandom_range(0, 2);
            e.misal = exp_misal(f3, a[1:0]);
            e.we    = we;
            e.addr  = {a[31:2], 2'b00};
            e.be    = exp_be(f3, a[1:0]);
            e.wdata = exp_wdata(f3, d);
            e.reqs  = e.misal ? 0 : gw + 1;
            e.lat   = e.misal ? 1 : (we ? gw + 2 : gw + 3);
            e.rdata = (e.misal || we) ? last_rdata : exp_load(f3, a[1:0], w);
            sb_q.push_back(e);
            run_op(we, f3, a, d, w, gw);
            e = sb_q.pop_front();
            n_cmp++; if (o_lat !== e.lat || o_reqs !== e.reqs) begin n_fail++; $display("FAIL b2b_timing[%0d]: got lat=%0d reqs=%0d expected %0d %0d", i, o_lat, o_reqs, e.lat, e.reqs); end
            n_cmp++; if (o_rdata !== e.rdata || o_misal !== e.misal) begin n_fail++; $display("FAIL b2b_result[%0d]: got rdata=%h mis=%b expected %h %b (f3=%b a=%h)", i, o_rdata, o_misal, e.rdata, e.misal, f3, a); end
            n_cmp++; if (o_extra !== 0 || !o_stall_ok || !o_stable) begin n_fail++; $display("FAIL b2b_handshake[%0d]: got extra=%0d stall_ok=%0d stable=%0d expected 0 1 1", i, o_extra, o_stall_ok, o_stable); end
            if (e.reqs > 0) begin
                n_cmp++; if (o_addr !== e.addr || o_we !== e.we) begin n_fail++; $display("FAIL b2b_addr[%0d]: got addr=%h we=%b expected %h %b", i, o_addr, o_we, e.addr, e.we); end
                if (we) begin
                    n_cmp++; if (o_be !== e.be || o_wdata !== e.wdata) begin n_fail++; $display("FAIL b2b_store[%0d]: got be=%b wdata=%h expected %b %h", i, o_be, o_wdata, e.be, e.wdata); end
                end
            end
            last_rdata = e.rdata;
        end
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_load_half();
        test_store_byte();
        test_store_stall();
        test_misalign();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters: none; all widths fixed (32-bit data/address, 4-bit byte enable).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 lsu_valid  input  1  core request; held high until lsu_done.
REQ-005 lsu_we  input  1  1 = store, 0 = load.
REQ-006 lsu_funct3  input  3  RV32I width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-007 lsu_addr  input  32  byte address.
REQ-008 lsu_wdata  input  32  store data from rs2.
REQ-009 lsu_rdata  output  32  extended load result for the register write-back path; valid when lsu_done=1.
REQ-010 lsu_done  output  1  one-cycle completion pulse.
REQ-011 lsu_stall  output  1  = lsu_valid & ~lsu_done, combinational.
REQ-012 lsu_misalign  output  1  misaligned-access flag, valid with lsu_done.
REQ-013 mem_req, mem_we  output  1 each  bus request and direction.
REQ-014 mem_addr  output  32  word-aligned address ({lsu_addr[31:2],2'b00}).
REQ-015 mem_wdata  output  32  lane-replicated store data; mem_be  output  4  byte enables.
REQ-016 mem_gnt, mem_rvalid  input  1 each; mem_rdata  input  32  memory word.

Function
REQ-017 FSM states IDLE, REQ, WAIT, DONE; encoding free.
REQ-018 IDLE: lsu_valid=1 -> latch we/funct3/addr/wdata, go REQ; otherwise stay.
REQ-019 REQ: mem_req=1 with registered mem_* outputs stable until mem_gnt=1; on gnt, store -> DONE, load -> WAIT.
REQ-020 WAIT: on mem_rvalid=1 capture extended data into lsu_rdata, go DONE; mem_rvalid never sampled in other states.
REQ-021 DONE: lsu_done=1 for exactly one cycle, then IDLE; lsu_rdata holds until next load completes.
REQ-022 Latency with gnt in first REQ cycle and rvalid next cycle: load done 3 cycles, store 2 cycles after lsu_valid sampled in IDLE.
REQ-023 Store: SB -> wdata byte replicated x4, be=4'b0001<<addr[1:0]; SH -> halfword replicated x2, be=addr[1]?1100:0011; SW -> be=1111.
REQ-024 Load: byte lane addr[1:0], halfword lane addr[1]; B/H sign-extend, BU/HU zero-extend, W passes word.
REQ-025 Unsupported funct3 (011, 110, 111 loads; any funct3[1:0]=11 store) treated as word access.
REQ-026 mem_req=0 in IDLE, WAIT, DONE; exactly one bus transaction per request.

Reset
REQ-027 rst_n=0 forces IDLE immediately; lsu_rdata=0, lsu_done=0, lsu_misalign=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0.
REQ-028 Reset mid-transaction abandons it with no done pulse; a late mem_rvalid after reset is ignored.

Configuration
REQ-029 Macro LSU_MISALIGN_TRAP_EN defined: H/HU/SH with addr[0]=1 or W/SW with addr[1:0]!=0 -> IDLE goes directly to DONE, no bus request, lsu_misalign=1 with lsu_done, lsu_rdata unchanged.
REQ-030 Macro not defined: lsu_misalign tied 0; unused low address bits ignored, access proceeds at lane per REQ-023/024.

Verification
REQ-031 LB addr=0x1003, mem_rdata=0x80FF_1234, gnt and rvalid immediate -> lsu_rdata=0xFFFF_FF80, done 3 cycles after valid.
REQ-032 LHU addr=0x2002, mem_rdata=0xBEEF_0000 -> lsu_rdata=0x0000_BEEF; LH same -> 0xFFFF_BEEF.
REQ-033 SB addr=0x3001, wdata=0x0000_00A5 -> mem_be=0010, mem_wdata=0xA5A5_A5A5, mem_addr=0x3000, done 2 cycles after valid.
REQ-034 SW with mem_gnt held low 4 cycles -> mem_req high and mem_* stable 5 cycles, lsu_stall high throughout, single done pulse.
REQ-035 LW addr=0x4002: with LSU_MISALIGN_TRAP_EN -> no mem_req, done+misalign next cycle; without -> normal word read of 0x4000.
REQ-036 rst_n low in WAIT, then rvalid arrives -> state IDLE, no lsu_done, lsu_rdata=0.
